// File: rtl/trdb_unalign8.sv
// trdb_unalign8: rebuilds length-prefixed byte packets from a packed word stream
module trdb_unalign8 #(
    parameter int DATA_WIDTH = 32,
    parameter int MAX_BYTES  = 8
) (
    input  logic                             clk_i,
    input  logic                             rst_ni,
    input  logic [DATA_WIDTH-1:0]            data_i,
    input  logic                             valid_i,
    output logic                             grant_o,
    input  logic                             flush_i,
    output logic                             flush_confirm_o,
    output logic [8*MAX_BYTES-1:0]           packet_bits_o,
    output logic [$clog2(MAX_BYTES+1)-1:0]   packet_bytes_o,
    output logic                             valid_o,
    input  logic                             grant_i,
    output logic                             err_o
);
    localparam int DATA_BYTES = DATA_WIDTH / 8;
    localparam int BW = $clog2(DATA_BYTES + 1);
    localparam int CW = $clog2(MAX_BYTES + 1);
    localparam int NW = BW > CW ? BW : CW;
    localparam int PW = 8 * MAX_BYTES;

    typedef enum logic [1:0] {HEADER, PAYLOAD, EMIT} state_e;

    state_e                state_q, state_d;
    logic [DATA_WIDTH-1:0] word_q, word_d;
    logic                  word_valid_q, word_valid_d;
    logic [BW-1:0]         byte_idx_q, byte_idx_d;
    logic [PW-1:0]         pkt_q, pkt_d;
    logic [CW-1:0]         cnt_q, cnt_d, rem_q, rem_d;
    logic                  err_q, err_d;

    logic [DATA_WIDTH-1:0] rest;
    logic [7:0]            hdr;
    logic [NW-1:0]         avail, take;
    logic [PW-1:0]         ins;
    logic                  consume_last, flush_ok;

    // Byte extraction, FSM next state, word-buffer handshake and flush handling
    always_comb begin
        state_d      = state_q;
        word_d       = word_q;
        word_valid_d = word_valid_q;
        byte_idx_d   = byte_idx_q;
        pkt_d        = pkt_q;
        cnt_d        = cnt_q;
        rem_d        = rem_q;
        err_d        = err_q;
        consume_last = 1'b0;
        rest  = word_q >> (8 * byte_idx_q);
        hdr   = rest[7:0];
        avail = NW'(DATA_BYTES) - NW'(byte_idx_q);
        take  = (NW'(rem_q) < avail) ? NW'(rem_q) : avail;
        ins   = PW'(rest & ~({DATA_WIDTH{1'b1}} << (8 * take))) << (8 * cnt_q);
        flush_ok = flush_i && (state_q != EMIT);
        case (state_q)
            HEADER: if (word_valid_q) begin
                if (hdr > 8'(MAX_BYTES)) begin
                    err_d        = 1'b1;
                    word_valid_d = 1'b0;
                    consume_last = 1'b1;
                end else begin
                    byte_idx_d   = byte_idx_q + 1'b1;
                    consume_last = (byte_idx_d == BW'(DATA_BYTES));
                    word_valid_d = !consume_last;
                    if (hdr != '0) begin
                        pkt_d   = '0;
                        cnt_d   = '0;
                        rem_d   = CW'(hdr);
                        state_d = PAYLOAD;
                    end
                end
            end
            PAYLOAD: if (word_valid_q) begin
                pkt_d        = pkt_q | ins;
                cnt_d        = cnt_q + CW'(take);
                rem_d        = rem_q - CW'(take);
                byte_idx_d   = byte_idx_q + BW'(take);
                consume_last = (byte_idx_d == BW'(DATA_BYTES));
                word_valid_d = !consume_last;
                if (rem_d == '0) state_d = EMIT;
            end
            EMIT: if (grant_i) state_d = HEADER;
            default: state_d = HEADER;
        endcase
        grant_o = !flush_i && (!word_valid_q || consume_last);
        if (valid_i && grant_o) begin
            word_d       = data_i;
            byte_idx_d   = '0;
            word_valid_d = 1'b1;
        end
        if (flush_ok) begin
            word_valid_d = 1'b0;
            byte_idx_d   = '0;
            pkt_d        = '0;
            cnt_d        = '0;
            rem_d        = '0;
            state_d      = HEADER;
        end
    end

    // State registers, cleared asynchronously
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= HEADER;
            word_q       <= '0;
            word_valid_q <= 1'b0;
            byte_idx_q   <= '0;
            pkt_q        <= '0;
            cnt_q        <= '0;
            rem_q        <= '0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            word_q       <= word_d;
            word_valid_q <= word_valid_d;
            byte_idx_q   <= byte_idx_d;
            pkt_q        <= pkt_d;
            cnt_q        <= cnt_d;
            rem_q        <= rem_d;
            err_q        <= err_d;
        end
    end

    assign valid_o         = (state_q == EMIT);
    assign packet_bits_o   = valid_o ? pkt_q : '0;
    assign packet_bytes_o  = valid_o ? cnt_q : '0;
    assign flush_confirm_o = flush_ok;
    assign err_o           = err_q;
endmodule
